// File: rtl/xup_shift_pkg.sv
// Shared encodings for the XUP sequential shifter: FSM states, direction and shift type.
package xup_shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT   = 1'b1;
  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic TYPE_ARITH = 1'b1;
  localparam logic TYPE_LOGIC = 1'b0;

endpackage

// File: rtl/xup_shift_step.sv
// Single-bit shift stage: left, logical right or arithmetic right by one position.
module xup_shift_step
  import xup_shift_pkg::*;
#(
  parameter int unsigned SIZE = 8
) (
  input  logic [SIZE-1:0] w_i,
  input  logic            dir_i,
  input  logic            shift_type_i,
  output logic [SIZE-1:0] w_o
);

  always_comb begin
    w_o = w_i;
    if (dir_i == DIR_LEFT) begin
      w_o = {w_i[SIZE-2:0], 1'b0};
    end else if (shift_type_i == TYPE_ARITH) begin
      w_o = {w_i[SIZE-1], w_i[SIZE-1:1]};
    end else begin
      w_o = {1'b0, w_i[SIZE-1:1]};
    end
  end

endmodule

// File: rtl/xup_shift_sequencer.sv
// Multi-cycle shift controller: captures one request, applies one 1-bit step per clock,
// then publishes the result with a single-cycle done pulse.
module xup_shift_sequencer
  import xup_shift_pkg::*;
#(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SIZE-1:0]  data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             dir,
  input  logic             shift_type,
  output logic             busy,
  output logic             done,
  output logic [SIZE-1:0]  data_out
);

  state_e           state_q;
  logic [SIZE-1:0]  work_q;
  logic [SIZE-1:0]  work_d;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic             type_q;
  logic             busy_q;
  logic             done_q;
  logic [SIZE-1:0]  data_out_q;

  xup_shift_step #(.SIZE(SIZE)) u_step (
    .w_i          (work_q),
    .dir_i        (dir_q),
    .shift_type_i (type_q),
    .w_o          (work_d)
  );

  // data_out is written only when entering DONE, so it holds the previous result while shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= DIR_RIGHT;
      type_q     <= TYPE_LOGIC;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            work_q <= data_in;
            cnt_q  <= amount;
            dir_q  <= dir;
            type_q <= shift_type;
            busy_q <= 1'b1;
            if (amount == AMT_W'(0)) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              data_out_q <= data_in;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            data_out_q <= work_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_xup_shift_sequencer.sv
// Directed bench for xup_shift_sequencer: latency, busy/done framing, results and ignored starts.
module tb_xup_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] amount;
  logic       dir;
  logic       shift_type;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_q = 8'h00;

  xup_shift_sequencer #(.SIZE(8), .AMT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .amount     (amount),
    .dir        (dir),
    .shift_type (shift_type),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept a request in the current cycle, then track busy/done/data_out until completion.
  task automatic run(input string tag, input logic [7:0] d, input logic [3:0] a,
                     input logic dr, input logic ty, input logic [7:0] exp);
    int lat;
    lat = int'(a) + 1;
    data_in = d; amount = a; dir = dr; shift_type = ty; start = 1'b1;
    tick();
    start = 1'b0; data_in = ~d; amount = ~a; dir = ~dr; shift_type = ~ty;
    for (int k = 1; k <= lat; k++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'(k == lat));
      if (k == lat) chk({tag, "_result"}, 32'(data_out), 32'(exp));
      else          chk({tag, "_hold"}, 32'(data_out), 32'(prev_q));
      tick();
    end
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_out"}, 32'(data_out), 32'(exp));
    prev_q = exp;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_in = 8'h00; amount = 4'd0; dir = 1'b0; shift_type = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(data_out), 32'h00);

    run("asr3", 8'hB4, 4'd3, 1'b0, 1'b1, 8'hF6);
    run("lsr3", 8'hB4, 4'd3, 1'b0, 1'b0, 8'h16);
    run("asl1", 8'h81, 4'd1, 1'b1, 1'b1, 8'h02);
    run("amt0", 8'h5A, 4'd0, 1'b0, 1'b0, 8'h5A);
    run("asr12", 8'h80, 4'd12, 1'b0, 1'b1, 8'hFF);
    run("lsr12", 8'h80, 4'd12, 1'b0, 1'b0, 8'h00);
    run("lsl15", 8'hFF, 4'd15, 1'b1, 1'b0, 8'h00);

    // Starts during SHIFT and DONE must be dropped; a start right after DONE is taken.
    data_in = 8'h0F; amount = 4'd4; dir = 1'b1; shift_type = 1'b0; start = 1'b1;
    tick();                                   // T+1
    start = 1'b0;
    tick();                                   // T+2
    data_in = 8'hAA; amount = 4'd1; dir = 1'b0; start = 1'b1;
    tick();                                   // T+3
    start = 1'b0;
    chk("ign_t3_busy", 32'(busy), 32'd1);
    chk("ign_t3_done", 32'(done), 32'd0);
    chk("ign_t3_out", 32'(data_out), 32'(prev_q));
    tick();                                   // T+4
    chk("ign_t4_done", 32'(done), 32'd0);
    tick();                                   // T+5
    chk("ign_t5_done", 32'(done), 32'd1);
    chk("ign_t5_out", 32'(data_out), 32'hF0);
    data_in = 8'hAA; amount = 4'd1; dir = 1'b0; start = 1'b1;
    tick();                                   // T+6
    start = 1'b0;
    chk("ign_t6_busy", 32'(busy), 32'd0);
    chk("ign_t6_done", 32'(done), 32'd0);
    chk("ign_t6_out", 32'(data_out), 32'hF0);
    prev_q = 8'hF0;
    run("after_ign", 8'h55, 4'd2, 1'b1, 1'b0, 8'h54);

    // Reset in the middle of a 5-step request: no done, outputs cleared.
    data_in = 8'hC3; amount = 4'd5; dir = 1'b0; shift_type = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_out", 32'(data_out), 32'h00);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("mid_no_done", 32'(done), 32'd0);
      chk("mid_no_busy", 32'(busy), 32'd0);
    end
    prev_q = 8'h00;
    run("post_rst", 8'h3C, 4'd2, 1'b0, 1'b1, 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
